// File: rtl/zap_postalu_pipe.sv
// -----------------------------------------------------------------------------
// zap_postalu_pipe
//
// Purpose:
//   Post-ALU pipeline on the memory path. DEPTH register stages sit between the
//   ALU and memory/writeback. Each stage carries one control bundle and one
//   opaque data payload. The pipe supports:
//     - a global data-stall hold,
//     - a flush from writeback,
//     - a sticky fault-sleep state that turns every new entry into a bubble
//       until the next flush.
//   Priority at every clock edge: flush > stall > advance.
//
// Parameters:
//   DEPTH      number of pipeline stages (1..8)
//   FLAG_WDT   width of the CPSR flag field
//   PAYLOAD_W  width of the opaque data payload
//   DCMP_W     width of the decompile (debug text) field
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_clear_from_writeback    flush: clears control fields of every stage
//   i_data_stall              freezes every stage
//   i_data_mem_fault          fault on the entry being accepted this cycle
//   i_dav .. i_wb_stb         control bundle of the incoming entry
//   i_payload                 opaque data fields of the incoming entry
//   i_decompile(_valid)       debug text of the incoming entry
//   o_dav .. o_decompile_valid  contents of the last stage (stage DEPTH-1)
//   o_sleep                   fault-sleep state
//   o_occupancy               number of stages holding a valid entry
//
// Configuration macro:
//   ZAP_POSTALU_DECOMPILE_EN  when defined, the decompile text and its valid
//                             bit are piped with the entry. When undefined, no
//                             decompile storage exists and both decompile
//                             outputs are tied to zero.
// -----------------------------------------------------------------------------
module zap_postalu_pipe #(
    parameter int DEPTH     = 2,
    parameter int FLAG_WDT  = 32,
    parameter int PAYLOAD_W = 128,
    parameter int DCMP_W    = 512
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_clear_from_writeback,
    input  logic                           i_data_stall,
    input  logic                           i_data_mem_fault,
    input  logic                           i_dav,
    input  logic                           i_uop_last,
    input  logic [4:0]                     i_exc,
    input  logic [FLAG_WDT-1:0]            i_flags,
    input  logic                           i_mem_load,
    input  logic                           i_wb_cyc,
    input  logic                           i_wb_stb,
    input  logic [PAYLOAD_W-1:0]           i_payload,
    input  logic [DCMP_W-1:0]              i_decompile,
    input  logic                           i_decompile_valid,
    output logic                           o_dav,
    output logic                           o_uop_last,
    output logic [4:0]                     o_exc,
    output logic [FLAG_WDT-1:0]            o_flags,
    output logic                           o_mem_load,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic [PAYLOAD_W-1:0]           o_payload,
    output logic [DCMP_W-1:0]              o_decompile,
    output logic                           o_decompile_valid,
    output logic                           o_sleep,
    output logic [$clog2(DEPTH+1)-1:0]     o_occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // -------------------------------------------------------------------------
    // Stage storage
    // -------------------------------------------------------------------------
    logic                 dav_reg      [DEPTH];
    logic                 uop_last_reg [DEPTH];
    logic [4:0]           exc_reg      [DEPTH];
    logic [FLAG_WDT-1:0]  flags_reg    [DEPTH];
    logic                 mem_load_reg [DEPTH];
    logic                 wb_cyc_reg   [DEPTH];
    logic                 wb_stb_reg   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_reg  [DEPTH];

    // Value each stage loads on an advance.
    logic                 dav_next      [DEPTH];
    logic                 uop_last_next [DEPTH];
    logic [4:0]           exc_next      [DEPTH];
    logic [FLAG_WDT-1:0]  flags_next    [DEPTH];
    logic                 mem_load_next [DEPTH];
    logic                 wb_cyc_next   [DEPTH];
    logic                 wb_stb_next   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_next  [DEPTH];

    logic                 sleep_reg;
    logic [OCC_W-1:0]     occ_reg;
    logic [OCC_W-1:0]     occ_next;

    // A new entry is killed (control fields forced to zero) when it faults or
    // when the pipe is already asleep. Its payload is still captured.
    logic kill_in;
    logic accept_in;
    logic advance;

    assign kill_in   = i_data_mem_fault | sleep_reg;
    assign accept_in = i_dav & ~kill_in;
    assign advance   = ~i_clear_from_writeback & ~i_data_stall;

    // -------------------------------------------------------------------------
    // Per-stage next-value selection and registers
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign dav_next[gi]      = accept_in;
                assign uop_last_next[gi] = i_uop_last & ~kill_in;
                assign exc_next[gi]      = kill_in ? 5'd0 : i_exc;
                assign flags_next[gi]    = kill_in ? '0 : i_flags;
                assign mem_load_next[gi] = i_mem_load & ~kill_in;
                assign wb_cyc_next[gi]   = i_wb_cyc & ~kill_in;
                assign wb_stb_next[gi]   = i_wb_stb & ~kill_in;
                assign payload_next[gi]  = i_payload;
            end else begin : g_body
                assign dav_next[gi]      = dav_reg[gi-1];
                assign uop_last_next[gi] = uop_last_reg[gi-1];
                assign exc_next[gi]      = exc_reg[gi-1];
                assign flags_next[gi]    = flags_reg[gi-1];
                assign mem_load_next[gi] = mem_load_reg[gi-1];
                assign wb_cyc_next[gi]   = wb_cyc_reg[gi-1];
                assign wb_stb_next[gi]   = wb_stb_reg[gi-1];
                assign payload_next[gi]  = payload_reg[gi-1];
            end

            // Control fields: cleared by flush, held by stall.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    dav_reg[gi]      <= 1'b0;
                    uop_last_reg[gi] <= 1'b0;
                    exc_reg[gi]      <= 5'd0;
                    flags_reg[gi]    <= '0;
                    mem_load_reg[gi] <= 1'b0;
                    wb_cyc_reg[gi]   <= 1'b0;
                    wb_stb_reg[gi]   <= 1'b0;
                end else if (i_clear_from_writeback) begin
                    dav_reg[gi]      <= 1'b0;
                    uop_last_reg[gi] <= 1'b0;
                    exc_reg[gi]      <= 5'd0;
                    flags_reg[gi]    <= '0;
                    mem_load_reg[gi] <= 1'b0;
                    wb_cyc_reg[gi]   <= 1'b0;
                    wb_stb_reg[gi]   <= 1'b0;
                end else if (!i_data_stall) begin
                    dav_reg[gi]      <= dav_next[gi];
                    uop_last_reg[gi] <= uop_last_next[gi];
                    exc_reg[gi]      <= exc_next[gi];
                    flags_reg[gi]    <= flags_next[gi];
                    mem_load_reg[gi] <= mem_load_next[gi];
                    wb_cyc_reg[gi]   <= wb_cyc_next[gi];
                    wb_stb_reg[gi]   <= wb_stb_next[gi];
                end
            end

            // Payload is data only: a flush leaves it untouched, so it only
            // moves on an advance.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    payload_reg[gi] <= '0;
                end else if (advance) begin
                    payload_reg[gi] <= payload_next[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Optional decompile (debug text) pipe
    // -------------------------------------------------------------------------
`ifdef ZAP_POSTALU_DECOMPILE_EN
    logic [DCMP_W-1:0] dcmp_reg        [DEPTH];
    logic              dcmp_valid_reg  [DEPTH];
    logic [DCMP_W-1:0] dcmp_next       [DEPTH];
    logic              dcmp_valid_next [DEPTH];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dcmp
            if (gi == 0) begin : g_head
                assign dcmp_next[gi]       = i_decompile;
                assign dcmp_valid_next[gi] = i_decompile_valid & ~kill_in;
            end else begin : g_body
                assign dcmp_next[gi]       = dcmp_reg[gi-1];
                assign dcmp_valid_next[gi] = dcmp_valid_reg[gi-1];
            end

            // The valid bit follows the control-field rules.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    dcmp_valid_reg[gi] <= 1'b0;
                end else if (i_clear_from_writeback) begin
                    dcmp_valid_reg[gi] <= 1'b0;
                end else if (!i_data_stall) begin
                    dcmp_valid_reg[gi] <= dcmp_valid_next[gi];
                end
            end

            // The text follows the payload rules.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    dcmp_reg[gi] <= '0;
                end else if (advance) begin
                    dcmp_reg[gi] <= dcmp_next[gi];
                end
            end
        end
    endgenerate

    assign o_decompile       = dcmp_reg[DEPTH-1];
    assign o_decompile_valid = dcmp_valid_reg[DEPTH-1];
`else
    // Inputs are folded into a sink so the feature-off build stays lint-clean.
    logic unused_decompile;
    assign unused_decompile  = ^{i_decompile, i_decompile_valid};
    assign o_decompile       = '0;
    assign o_decompile_valid = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Fault-sleep state: set by a fault on an accepted cycle, cleared only by
    // flush or reset. A fault seen during a stall is ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sleep_reg <= 1'b0;
        end else if (i_clear_from_writeback) begin
            sleep_reg <= 1'b0;
        end else if (!i_data_stall && i_data_mem_fault) begin
            sleep_reg <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy: count of stages with dav=1. The last stage's entry leaves on
    // every advance, and at most one enters, so the count stays in 0..DEPTH.
    // -------------------------------------------------------------------------
    always_comb begin
        occ_next = occ_reg + OCC_W'(accept_in) - OCC_W'(dav_reg[DEPTH-1]);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            occ_reg <= '0;
        end else if (i_clear_from_writeback) begin
            occ_reg <= '0;
        end else if (!i_data_stall) begin
            occ_reg <= occ_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: last-stage registers only, no combinational input path.
    // -------------------------------------------------------------------------
    assign o_dav       = dav_reg[DEPTH-1];
    assign o_uop_last  = uop_last_reg[DEPTH-1];
    assign o_exc       = exc_reg[DEPTH-1];
    assign o_flags     = flags_reg[DEPTH-1];
    assign o_mem_load  = mem_load_reg[DEPTH-1];
    assign o_wb_cyc    = wb_cyc_reg[DEPTH-1];
    assign o_wb_stb    = wb_stb_reg[DEPTH-1];
    assign o_payload   = payload_reg[DEPTH-1];
    assign o_sleep     = sleep_reg;
    assign o_occupancy = occ_reg;

endmodule

// File: tb/tb_zap_postalu_pipe.sv
// -----------------------------------------------------------------------------
// tb_zap_postalu_pipe
//
// Bench for zap_postalu_pipe at DEPTH=2 in the default build (decompile
// feature off). A table of per-cycle stimulus records with expected last-stage
// outputs drives the main sequence (latency, stall, fault/sleep, flush,
// fault+flush, fault-during-stall); a payload scoreboard checks ordering.
// Hand-written sequences cover the reset state and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_zap_postalu_pipe;

    localparam int DEPTH = 2;
    localparam int FW    = 32;
    localparam int PW    = 128;
    localparam int DW    = 512;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           stall;
    logic           fault;
    logic           dav;
    logic           uop_last;
    logic [4:0]     exc;
    logic [FW-1:0]  flags;
    logic           mem_load;
    logic           wb_cyc;
    logic           wb_stb;
    logic [PW-1:0]  payload;
    logic [DW-1:0]  dcmp;
    logic           dcmp_valid;

    logic           o_dav;
    logic           o_uop_last;
    logic [4:0]     o_exc;
    logic [FW-1:0]  o_flags;
    logic           o_mem_load;
    logic           o_wb_cyc;
    logic           o_wb_stb;
    logic [PW-1:0]  o_payload;
    logic [DW-1:0]  o_dcmp;
    logic           o_dcmp_valid;
    logic           o_sleep;
    logic [1:0]     o_occupancy;

    always #5 clk = ~clk;

    zap_postalu_pipe #(
        .DEPTH     (DEPTH),
        .FLAG_WDT  (FW),
        .PAYLOAD_W (PW),
        .DCMP_W    (DW)
    ) dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_clear_from_writeback (clear),
        .i_data_stall           (stall),
        .i_data_mem_fault       (fault),
        .i_dav                  (dav),
        .i_uop_last             (uop_last),
        .i_exc                  (exc),
        .i_flags                (flags),
        .i_mem_load             (mem_load),
        .i_wb_cyc               (wb_cyc),
        .i_wb_stb               (wb_stb),
        .i_payload              (payload),
        .i_decompile            (dcmp),
        .i_decompile_valid      (dcmp_valid),
        .o_dav                  (o_dav),
        .o_uop_last             (o_uop_last),
        .o_exc                  (o_exc),
        .o_flags                (o_flags),
        .o_mem_load             (o_mem_load),
        .o_wb_cyc               (o_wb_cyc),
        .o_wb_stb               (o_wb_stb),
        .o_payload              (o_payload),
        .o_decompile            (o_dcmp),
        .o_decompile_valid      (o_dcmp_valid),
        .o_sleep                (o_sleep),
        .o_occupancy            (o_occupancy)
    );

    typedef struct {
        logic          stall;
        logic          flush;
        logic          fault;
        logic          dav;
        logic [PW-1:0] pay;
        logic [FW-1:0] flg;
        logic          e_dav;
        logic [PW-1:0] e_pay;
        logic [FW-1:0] e_flg;
        logic [1:0]    e_occ;
        logic          e_sleep;
    } vec_t;

    vec_t          vecs[$];
    logic [PW-1:0] sb_q[$];
    bit            sb_sleep;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Control fields of a valid entry are derived from its payload so that a
    // killed entry is visibly different from a passed one.
    task automatic drive(input logic s, input logic f, input logic flt, input logic d,
                         input logic [PW-1:0] p, input logic [FW-1:0] fl);
        stall    = s;
        clear    = f;
        fault    = flt;
        dav      = d;
        payload  = p;
        flags    = fl;
        uop_last = d;
        exc      = d ? p[4:0] : 5'd0;
        mem_load = d;
        wb_cyc   = d;
        wb_stb   = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dav"},   o_dav,       0);
        check({tag, "_pay"},   o_payload,   0);
        check({tag, "_flags"}, o_flags,     0);
        check({tag, "_exc"},   o_exc,       0);
        check({tag, "_occ"},   o_occupancy, 0);
        check({tag, "_sleep"}, o_sleep,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   adv;
        logic [PW-1:0] exp_pay;

        rst_n      = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        dcmp       = {16{32'hDEADBEEF}};
        dcmp_valid = 1'b1;
        sb_sleep   = 0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        //                stall flush fault dav pay          flags           e_dav e_pay        e_flags         occ  sleep
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'hA5,32'h1,        1'b0,128'h0, 32'h0,        2'd1,1'b0}); // 0
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h01,32'h2,        1'b1,128'hA5,32'h1,        2'd2,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h02,32'h3,        1'b1,128'h01,32'h2,        2'd2,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b1,128'h02,32'h3,        2'd1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h11,32'h11,       1'b0,128'h00,32'h0,        2'd1,1'b0}); // 5
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h12,32'h12,       1'b1,128'h11,32'h11,       2'd2,1'b0});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1,1'b0,1'b0,1'b1,128'h13,32'h13,   1'b1,128'h11,32'h11,       2'd2,1'b0}); // 7..10
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h13,32'h13,       1'b1,128'h12,32'h12,       2'd2,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b1,128'h13,32'h13,       2'd1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h21,32'h21,       1'b0,128'h00,32'h0,        2'd1,1'b0}); // 14
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h22,32'h22,       1'b1,128'h21,32'h21,       2'd2,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,128'h23,32'hF0000000, 1'b1,128'h22,32'h22,       2'd1,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h24,32'h24,       1'b0,128'h23,32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h25,32'h25,       1'b0,128'h24,32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h26,32'h26,       1'b0,128'h25,32'h0,        2'd0,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h25,32'h0,        2'd0,1'b0}); // 20
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h31,32'h31,       1'b0,128'h26,32'h0,        2'd1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h32,32'h32,       1'b1,128'h31,32'h31,       2'd2,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,128'h33,32'h33,       1'b1,128'h32,32'h32,       2'd1,1'b1});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h32,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h41,32'h41,       1'b0,128'h33,32'h0,        2'd1,1'b0}); // 25
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b1,128'h41,32'h41,       2'd1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,128'h51,32'h51,       1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,128'h52,32'h52,       1'b0,128'h00,32'h0,        2'd1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b1,128'h52,32'h52,       2'd1,1'b0}); // 30
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,128'h61,32'h61,       1'b0,128'h00,32'h0,        2'd0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,128'h00,32'h0,        1'b0,128'h00,32'h0,        2'd0,1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.stall, v.flush, v.fault, v.dav, v.pay, v.flg);

            // Scoreboard push: entry accepted at this edge.
            adv = !v.flush && !v.stall;
            if (v.flush) begin
                sb_q.delete();
                sb_sleep = 0;
            end else if (!v.stall) begin
                if (v.dav && !v.fault && !sb_sleep)
                    sb_q.push_back(v.pay);
                if (v.fault)
                    sb_sleep = 1;
            end

            @(posedge clk);
            #1;
            $display("[TB] vec %0d: dav=%0b pay=%0h flags=%0h occ=%0d sleep=%0b",
                     i, o_dav, o_payload, o_flags, o_occupancy, o_sleep);

            check($sformatf("v%0d_dav", i),      o_dav,       v.e_dav);
            check($sformatf("v%0d_pay", i),      o_payload,   v.e_pay);
            check($sformatf("v%0d_flags", i),    o_flags,     v.e_flg);
            check($sformatf("v%0d_exc", i),      o_exc,       v.e_dav ? v.e_pay[4:0] : 5'd0);
            check($sformatf("v%0d_uop", i),      o_uop_last,  v.e_dav);
            check($sformatf("v%0d_mload", i),    o_mem_load,  v.e_dav);
            check($sformatf("v%0d_cyc", i),      o_wb_cyc,    v.e_dav);
            check($sformatf("v%0d_stb", i),      o_wb_stb,    v.e_dav);
            check($sformatf("v%0d_occ", i),      o_occupancy, v.e_occ);
            check($sformatf("v%0d_sleep", i),    o_sleep,     v.e_sleep);
            check($sformatf("v%0d_dcmp_v", i),   o_dcmp_valid, 0);
            check($sformatf("v%0d_dcmp", i),     o_dcmp[PW-1:0], 0);

            // Scoreboard pop: one entry leaves per advancing edge with dav=1.
            if (adv && o_dav) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL v%0d_sb_extra: got entry %0h expected none", i, o_payload);
                end else begin
                    exp_pay = sb_q.pop_front();
                    check($sformatf("v%0d_sb_order", i), o_payload, exp_pay);
                end
            end
        end
        check("sb_drained", sb_q.size(), 0);

        // Asynchronous reset between clock edges while holding a valid entry
        // and asleep.
        drive(0, 0, 0, 1, 128'h71, 32'h71);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 1, 128'h72, 32'h72);
        @(posedge clk);
        #1;
        $display("[TB] pre-reset: dav=%0b pay=%0h sleep=%0b", o_dav, o_payload, o_sleep);
        check("prereset_dav",   o_dav,     1);
        check("prereset_pay",   o_payload, 128'h71);
        check("prereset_sleep", o_sleep,   1);
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset: dav=%0b pay=%0h occ=%0d sleep=%0b", o_dav, o_payload, o_occupancy, o_sleep);
        check_all_zero("areset");
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal pass after reset.
        drive(0, 0, 0, 1, 128'h81, 32'h81);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("[TB] post-reset: dav=%0b pay=%0h flags=%0h sleep=%0b", o_dav, o_payload, o_flags, o_sleep);
        check("postreset_dav",   o_dav,     1);
        check("postreset_pay",   o_payload, 128'h81);
        check("postreset_flags", o_flags,   32'h81);
        check("postreset_sleep", o_sleep,   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
